main_memory: RTL and testbench

MAIN_MEMORY -- requirements
Module: main_memory

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_line_array.sv | 46 ++++
 rtl/main_memory.sv | 135 +++++++++++++
 tb/tb_main_memory.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults and state encoding for the main_memory line model.
//   LINE_BITS_DEF  : default width of one line transfer (bits)
//   MEM_BYTES_DEF  : default storage size (bytes)
//   LATENCY_DEF    : default request-to-ready latency (cycles)
//   mem_state_t    : controller states IDLE / WAIT / RESP
package mem_pkg;

  localparam int LINE_BITS_DEF = 128;
  localparam int MEM_BYTES_DEF = 1024;
  localparam int LATENCY_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: line-wide synchronous single-port storage.
//   clk   : clock, rising edge
//   we    : write enable; wdata is stored at line idx on the edge
//   idx   : line index used for both read and write
//   wdata : line to store
//   rdata : registered read of line idx (read-before-write on the same edge)
// Power-up contents: byte i of the whole array holds i[7:0]. There is no reset,
// so a reset of the surrounding logic leaves the stored data alone.
module mem_line_array #(
  parameter int LINE_BITS = 128,
  parameter int DEPTH     = 64,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  localparam int MEM_BITS = DEPTH * LINE_BITS;

  // Line l occupies bits [l*LINE_BITS +: LINE_BITS] and byte k of a line sits
  // at [8k +: 8], so the flat image is simply byte i at bits [8i +: 8].
  function automatic logic [MEM_BITS-1:0] power_up_image();
    logic [MEM_BITS-1:0] img;
    img = '0;
    for (int i = 0; i < MEM_BITS / 8; i++) begin
      img[8*i +: 8] = 8'(i);
    end
    return img;
  endfunction

  logic [DEPTH-1:0][LINE_BITS-1:0] mem_array = power_up_image();
  logic [LINE_BITS-1:0]            rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[idx] <= wdata;
    end
    rdata_reg <= mem_array[idx];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/main_memory.sv
// main_memory: fixed-latency line memory behind a cache.
//   clk               : clock, rising edge
//   reset             : synchronous, active-high; aborts any request in flight
//   in_mem_read_en    : line fill request (level)
//   in_mem_write_en   : line write-back request (level); wins over a read
//   in_mem_addr       : byte address; offset and high bits ignored (wraps)
//   in_mem_write_data : line to write
//   out_mem_read_data : last line read; held until the next read completes
//   out_mem_ready     : one-cycle completion pulse, LATENCY cycles after accept
//   out_busy          : high while a request is in flight (WAIT and RESP)
module main_memory
  import mem_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_mem_read_en,
  input  logic                 in_mem_write_en,
  input  logic [31:0]          in_mem_addr,
  input  logic [LINE_BITS-1:0] in_mem_write_data,
  output logic [LINE_BITS-1:0] out_mem_read_data,
  output logic                 out_mem_ready,
  output logic                 out_busy
);

  localparam int BYTES_PER_LINE = LINE_BITS / 8;
  localparam int OFF_W          = $clog2(BYTES_PER_LINE);
  localparam int DEPTH          = MEM_BYTES / BYTES_PER_LINE;
  localparam int IDX_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W          = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LATENCY - 1);

  mem_state_t           state_reg, state_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 write_op_reg, write_op_next;
  logic [LINE_BITS-1:0] wdata_reg, wdata_next;
  logic [LINE_BITS-1:0] read_data_reg, read_data_next;

  logic [IDX_W-1:0]     req_idx;
  logic [IDX_W-1:0]     array_idx;
  logic                 array_we;
  logic [LINE_BITS-1:0] array_rdata;

  // Masking with DEPTH-1 drops both the in-line offset and everything above
  // the storage size, which gives the modulo-MEM_BYTES wrap.
  assign req_idx = IDX_W'((in_mem_addr >> OFF_W) & 32'(DEPTH - 1));

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    idx_next       = idx_reg;
    write_op_next  = write_op_reg;
    wdata_next     = wdata_reg;
    read_data_next = read_data_reg;
    array_we       = 1'b0;
    // Stored index by default; in IDLE the incoming index is presented so the
    // registered array read is already valid one cycle after acceptance,
    // which keeps LATENCY = 2 correct.
    array_idx      = idx_reg;

    case (state_reg)
      IDLE: begin
        array_idx = req_idx;
        if (in_mem_read_en || in_mem_write_en) begin
          state_next    = WAIT;
          count_next    = CNT_W'(1);
          idx_next      = req_idx;
          write_op_next = in_mem_write_en;
          wdata_next    = in_mem_write_data;
        end
      end
      WAIT: begin
        if (count_reg == LAST_COUNT) begin
          state_next = RESP;
          if (write_op_reg) begin
            array_we = 1'b1;
          end else begin
            read_data_next = array_rdata;
          end
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
        count_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      read_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      read_data_reg <= read_data_next;
    end
  end

  // Capture registers carry no reset: they are only consumed after a fresh
  // acceptance has loaded them.
  always_ff @(posedge clk) begin
    idx_reg      <= idx_next;
    write_op_reg <= write_op_next;
    wdata_reg    <= wdata_next;
  end

  // A reset landing on the final WAIT edge must not commit the write.
  mem_line_array #(
    .LINE_BITS (LINE_BITS),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (array_we && !reset),
    .idx   (array_idx),
    .wdata (wdata_reg),
    .rdata (array_rdata)
  );

  assign out_mem_read_data = read_data_reg;
  assign out_mem_ready     = (state_reg == RESP);
  assign out_busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

  logic         clk;
  logic         reset;
  logic         in_mem_read_en;
  logic         in_mem_write_en;
  logic [31:0]  in_mem_addr;
  logic [127:0] in_mem_write_data;
  logic [127:0] out_mem_read_data;
  logic         out_mem_ready;
  logic         out_busy;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE_100 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] LINE_3F0 = 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0;
  localparam logic [127:0] ALL_DD   = {16{8'hDD}};
  localparam logic [127:0] ALL_EE   = {16{8'hEE}};
  localparam logic [127:0] ALL_AA   = {16{8'hAA}};

  main_memory dut (
    .clk               (clk),
    .reset             (reset),
    .in_mem_read_en    (in_mem_read_en),
    .in_mem_write_en   (in_mem_write_en),
    .in_mem_addr       (in_mem_addr),
    .in_mem_write_data (in_mem_write_data),
    .out_mem_read_data (out_mem_read_data),
    .out_mem_ready     (out_mem_ready),
    .out_busy          (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Called at a negedge. Presents one request, lets it be accepted at the next
  // posedge (edge T), drops the enables in cycle 1 and watches cycles 1..13.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [127:0] wd,
                         output int first_rdy, output int pulses, output int busy_cyc);
    in_mem_read_en    = rd;
    in_mem_write_en   = wr;
    in_mem_addr       = addr;
    in_mem_write_data = wd;
    @(posedge clk);
    first_rdy = 0;
    pulses    = 0;
    busy_cyc  = 0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_mem_read_en  = 1'b0;
        in_mem_write_en = 1'b0;
      end
      if (out_busy) busy_cyc++;
      if (out_mem_ready) begin
        pulses++;
        if (first_rdy == 0) first_rdy = n;
      end
    end
  endtask

  initial begin
    int lat, pul, bsy;
    int rdy_cycles[$];
    int idle_busy;

    reset             = 1'b1;
    in_mem_read_en    = 1'b0;
    in_mem_write_en   = 1'b0;
    in_mem_addr       = '0;
    in_mem_write_data = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 128'(out_mem_ready), 128'(0));
    check_val("rst_busy", 128'(out_busy), 128'(0));
    check_val("rst_data", out_mem_read_data, '0);
    reset = 1'b0;
    @(negedge clk);

    // Plain read with latency and busy width
    run_req(1'b1, 1'b0, 32'h0000_0100, '0, lat, pul, bsy);
    check_val("rd100_latency", 128'(lat), 128'(10));
    check_val("rd100_pulses", 128'(pul), 128'(1));
    check_val("rd100_busy", 128'(bsy), 128'(10));
    check_val("rd100_data", out_mem_read_data, LINE_100);

    // Write then read back through a different offset in the same line
    run_req(1'b0, 1'b1, 32'h0000_0200, ALL_DD, lat, pul, bsy);
    check_val("wr200_latency", 128'(lat), 128'(10));
    check_val("wr200_pulses", 128'(pul), 128'(1));
    check_val("wr200_data_held", out_mem_read_data, LINE_100);
    run_req(1'b1, 1'b0, 32'h0000_0204, '0, lat, pul, bsy);
    check_val("rd204_data", out_mem_read_data, ALL_DD);

    // Address wrap
    run_req(1'b1, 1'b0, 32'hFFFF_FFFF, '0, lat, pul, bsy);
    check_val("rdFFFF_latency", 128'(lat), 128'(10));
    check_val("rdFFFF_data", out_mem_read_data, LINE_3F0);

    // Both enables: write wins, read data untouched
    run_req(1'b1, 1'b1, 32'h0000_0500, ALL_EE, lat, pul, bsy);
    check_val("both_pulses", 128'(pul), 128'(1));
    check_val("both_data_held", out_mem_read_data, LINE_3F0);
    run_req(1'b1, 1'b0, 32'h0000_0100, '0, lat, pul, bsy);
    check_val("rd100_after_both", out_mem_read_data, ALL_EE);

    // Reset in cycle 5 of a write to 0x300
    in_mem_write_en   = 1'b1;
    in_mem_addr       = 32'h0000_0300;
    in_mem_write_data = ALL_AA;
    @(posedge clk);
    pul = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) in_mem_write_en = 1'b0;
      if (out_mem_ready) pul++;
      if (n == 5) reset = 1'b1;
      if (n == 6) begin
        check_val("abort_busy", 128'(out_busy), 128'(0));
        check_val("abort_data", out_mem_read_data, '0);
        reset = 1'b0;
      end
    end
    check_val("abort_no_ready", 128'(pul), 128'(0));
    run_req(1'b1, 1'b0, 32'h0000_0300, '0, lat, pul, bsy);
    check_val("rd300_data", out_mem_read_data, LINE_100);

    // Read enable held high: one pulse per 11 cycles, idle gap after RESP
    in_mem_read_en = 1'b1;
    in_mem_addr    = 32'h0000_0000;
    @(posedge clk);
    idle_busy = 1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (out_mem_ready) rdy_cycles.push_back(n);
      if (n == 11) idle_busy = int'(out_busy);
      if (n == 32) in_mem_read_en = 1'b0;
    end
    check_val("held_pulses", 128'(rdy_cycles.size()), 128'(3));
    if (rdy_cycles.size() == 3) begin
      check_val("held_first", 128'(rdy_cycles[0]), 128'(10));
      check_val("held_gap1", 128'(rdy_cycles[1] - rdy_cycles[0]), 128'(11));
      check_val("held_gap2", 128'(rdy_cycles[2] - rdy_cycles[1]), 128'(11));
    end
    check_val("held_idle_gap", 128'(idle_busy), 128'(0));
    check_val("held_data", out_mem_read_data, LINE_100);
    repeat (13) @(negedge clk);
    check_val("final_idle", 128'(out_busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
